// File: rtl/ready_valid_pipe_pkg.sv
// Shared types and limits for the ready/valid retiming pipeline.
// Stage state encoding plus helpers that turn a state into handshake signals.
package ready_valid_pipe_pkg;

    localparam int MAX_DEPTH = 8;
    localparam int MAX_WIDTH = 1024;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_t;

    function automatic logic stage_can_accept(input stage_state_t s);
        return s != TWO;
    endfunction

    function automatic logic stage_has_data(input stage_state_t s);
        return s != EMPTY;
    endfunction

endpackage

// File: rtl/ready_valid_skid_stage.sv
// One registered skid stage: main register drives the output, skid register
// absorbs the beat that arrives while the downstream stalls. State is exported.
module ready_valid_skid_stage
    import ready_valid_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_ready,
    output logic [1:0]       state,
    output logic [WIDTH-1:0] out_data
);

    stage_state_t     cur_state;
    stage_state_t     nxt_state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_fire;
    logic             out_fire;
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid;

    // Both handshakes depend only on this stage's flops and the neighbour's signal.
    assign in_fire  = in_valid && stage_can_accept(cur_state);
    assign out_fire = out_ready && stage_has_data(cur_state);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur_state <= EMPTY;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state      = cur_state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (cur_state)
            EMPTY: begin
                if (in_fire) begin
                    load_main_in = 1'b1;
                    nxt_state    = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    load_skid = 1'b1;
                    nxt_state = TWO;
                end else if (out_fire) begin
                    nxt_state = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    load_main_skid = 1'b1;
                    nxt_state      = ONE;
                end
            end
            default: nxt_state = EMPTY;
        endcase
    end

    // Payload registers carry no reset; validity comes from the state alone.
    always_ff @(posedge clock) begin
        if (load_main_in) begin
            main_q <= in_data;
        end else if (load_main_skid) begin
            main_q <= skid_q;
        end
        if (load_skid) begin
            skid_q <= in_data;
        end
    end

    assign state    = cur_state;
    assign out_data = main_q;

endmodule

// File: rtl/ready_valid_pipe.sv
// Parametrised ready/valid retiming pipeline of DEPTH skid stages (DEPTH=0 is a wire).
// Optional beat counter output enabled by READY_VALID_PIPE_OCCUPANCY_EN.
module ready_valid_pipe
    import ready_valid_pipe_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 1,
    localparam int OCC_W = (DEPTH == 0) ? 1 : $clog2(2 * DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef READY_VALID_PIPE_OCCUPANCY_EN
    ,
    output logic [OCC_W-1:0] occupancy
`endif
);

    if (DEPTH < 0 || DEPTH > MAX_DEPTH || WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_param
        $error("ready_valid_pipe: WIDTH or DEPTH out of range");
    end

    if (DEPTH == 0) begin : g_bypass
        assign out_valid = in_valid;
        assign out_data  = in_data;
        assign in_ready  = out_ready;
`ifdef READY_VALID_PIPE_OCCUPANCY_EN
        assign occupancy = '0;
`endif
    end else begin : g_pipe
        // Index k is the boundary feeding stage k; index DEPTH is the output side.
        logic [DEPTH:0]   valid_c;
        logic [DEPTH:0]   ready_c;
        logic [WIDTH-1:0] data_c [DEPTH+1];
        logic [1:0]       stage_state [DEPTH];

        assign valid_c[0]     = in_valid;
        assign data_c[0]      = in_data;
        assign ready_c[DEPTH] = out_ready;

        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            ready_valid_skid_stage #(
                .WIDTH(WIDTH)
            ) u_stage (
                .clock    (clock),
                .reset_n  (reset_n),
                .in_valid (valid_c[k]),
                .in_data  (data_c[k]),
                .out_ready(ready_c[k+1]),
                .state    (stage_state[k]),
                .out_data (data_c[k+1])
            );
            assign valid_c[k+1] = stage_has_data(stage_state_t'(stage_state[k]));
            assign ready_c[k]   = stage_can_accept(stage_state_t'(stage_state[k]));
        end

        assign in_ready  = ready_c[0];
        assign out_valid = valid_c[DEPTH];
        assign out_data  = data_c[DEPTH];

`ifdef READY_VALID_PIPE_OCCUPANCY_EN
        logic in_fire;
        logic out_fire;

        assign in_fire  = in_valid && ready_c[0];
        assign out_fire = valid_c[DEPTH] && out_ready;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                occupancy <= '0;
            end else if (in_fire && !out_fire) begin
                occupancy <= occupancy + OCC_W'(1);
            end else if (out_fire && !in_fire) begin
                occupancy <= occupancy - OCC_W'(1);
            end
        end

`ifndef SYNTHESIS
        always @(posedge clock) begin
            if (reset_n) begin
                assert (int'(occupancy) <= 2 * DEPTH)
                else $error("ready_valid_pipe: occupancy %0d exceeds capacity", occupancy);
            end
        end
`endif
`endif
    end

endmodule

// File: tb/tb_ready_valid_pipe.sv
// Bench for ready_valid_pipe: four instances (DEPTH 2, 3, 4 and a DEPTH 0 bypass)
// checked against latency arithmetic and a queue model of accepted beats.
module tb_ready_valid_pipe;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    // A: DEPTH=2 for reset, latency, backpressure and mid-flight reset
    logic        a_rst_n, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    // B: DEPTH=3 streaming
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_data, b_out_data;
    // C: DEPTH=4 random stalls
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [31:0] c_in_data, c_out_data;
    // D: DEPTH=0 bypass, WIDTH=1
    logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready;
    logic [0:0]  d_in_data, d_out_data;
`ifdef READY_VALID_PIPE_OCCUPANCY_EN
    logic [2:0]  a_occ;
    logic [2:0]  b_occ;
    logic [3:0]  c_occ;
    logic [0:0]  d_occ;
`endif

    ready_valid_pipe #(.WIDTH(32), .DEPTH(2)) u_dut_a (
        .clock(clock), .reset_n(a_rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data)
`ifdef READY_VALID_PIPE_OCCUPANCY_EN
        , .occupancy(a_occ)
`endif
    );

    ready_valid_pipe #(.WIDTH(32), .DEPTH(3)) u_dut_b (
        .clock(clock), .reset_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
`ifdef READY_VALID_PIPE_OCCUPANCY_EN
        , .occupancy(b_occ)
`endif
    );

    ready_valid_pipe #(.WIDTH(32), .DEPTH(4)) u_dut_c (
        .clock(clock), .reset_n(rst_n),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data)
`ifdef READY_VALID_PIPE_OCCUPANCY_EN
        , .occupancy(c_occ)
`endif
    );

    ready_valid_pipe #(.WIDTH(1), .DEPTH(0)) u_dut_d (
        .clock(clock), .reset_n(rst_n),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data)
`ifdef READY_VALID_PIPE_OCCUPANCY_EN
        , .occupancy(d_occ)
`endif
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] exp_q[$];
    int accepted, exp_next, sent, seen, cycles;
    logic in_fired;

    initial begin
        rst_n = 1'b0;   a_rst_n = 1'b0;
        a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
        b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
        c_in_valid = 0; c_in_data = '0; c_out_ready = 0;
        d_in_valid = 0; d_in_data = '0; d_out_ready = 0;

        // ---- reset state, with in_valid held high on A
        repeat (2) @(posedge clock);
        #1; a_in_valid = 1; a_in_data = 32'h1234_0000; #3;
        check_value("rst_a_out_valid", a_out_valid, 0);
        check_value("rst_a_in_ready", a_in_ready, 1);
        check_value("rst_b_out_valid", b_out_valid, 0);
        check_value("rst_c_in_ready", c_in_ready, 1);
        @(posedge clock); #1; a_in_valid = 0; a_rst_n = 1; rst_n = 1;

        // ---- first-beat latency on DEPTH=2
        @(posedge clock); #1; a_in_valid = 1; a_in_data = 32'hA5A5_0001; a_out_ready = 1; #3;
        check_value("lat_t0_in_ready", a_in_ready, 1);
        check_value("lat_t0_out_valid", a_out_valid, 0);
        @(posedge clock); #1; a_in_valid = 0; #3;
        check_value("lat_t1_out_valid", a_out_valid, 0);
        @(posedge clock); #4;
        check_value("lat_t2_out_valid", a_out_valid, 1);
        check_value("lat_t2_out_data", a_out_data, 32'hA5A5_0001);

        // ---- backpressure: capacity of 2*DEPTH = 4 beats
        accepted = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock); #1;
            a_out_ready = 0; a_in_valid = 1; a_in_data = accepted; #3;
            if (a_in_ready) accepted++;
        end
        check_value("bp_accepted", accepted, 4);
        check_value("bp_in_ready_low", a_in_ready, 0);
        exp_next = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            a_in_valid = 0; a_out_ready = 1; #3;
            if (a_out_valid) begin
                check_value("bp_drain_data", a_out_data, exp_next);
                exp_next++;
            end
        end
        check_value("bp_drain_count", exp_next, 4);
        check_value("bp_in_ready_back", a_in_ready, 1);

        // ---- asynchronous reset with three beats in flight
        sent = 0;
        for (int i = 0; i < 10 && sent < 3; i++) begin
            @(posedge clock); #1;
            a_out_ready = 0; a_in_valid = 1; a_in_data = 32'h10 + sent; #3;
            if (a_in_ready) sent++;
        end
        check_value("mid_sent", sent, 3);
        @(posedge clock); #1; a_in_valid = 0; #2;
        check_value("mid_held_valid", a_out_valid, 1);
        a_rst_n = 0; #1;
        check_value("mid_rst_out_valid", a_out_valid, 0);
        check_value("mid_rst_in_ready", a_in_ready, 1);
        @(posedge clock); #1; a_rst_n = 1;
        @(posedge clock); #1; a_in_valid = 1; a_in_data = 32'h55; a_out_ready = 1; #3;
        check_value("mid_post_in_ready", a_in_ready, 1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1; a_in_valid = 0; #3;
            if (a_out_valid) begin
                check_value("mid_post_data", a_out_data, 32'h55);
                seen++;
            end
        end
        check_value("mid_post_count", seen, 1);

        // ---- streaming on DEPTH=3: beat i leaves at cycle i+3
        for (int i = 0; i < 110; i++) begin
            @(posedge clock); #1;
            b_out_ready = 1; b_in_valid = (i < 100); b_in_data = i; #3;
            if (i < 100) check_value("stream_in_ready", b_in_ready, 1);
            check_value("stream_out_valid", b_out_valid, (i >= 3 && i < 103));
            if (i >= 3 && i < 103) check_value("stream_out_data", b_out_data, i - 3);
        end

        // ---- random stalls on DEPTH=4 against a queue of accepted beats
        accepted = 0; cycles = 0; in_fired = 0;
        while (accepted < 10000 && cycles < 40000) begin
            @(posedge clock); #1;
            cycles++;
            if (in_fired) c_in_valid = 0;
            if (!c_in_valid && $urandom_range(0, 9) >= 2) begin
                c_in_valid = 1;
                c_in_data  = $urandom;
            end
            c_out_ready = ($urandom_range(0, 9) >= 2);
            #3;
`ifdef READY_VALID_PIPE_OCCUPANCY_EN
            check_value("rand_occupancy", c_occ, exp_q.size());
`endif
            if (exp_q.size() == 0) check_value("rand_empty_no_valid", c_out_valid, 0);
            if (c_out_valid && c_out_ready && exp_q.size() > 0)
                check_value("rand_out_data", c_out_data, exp_q.pop_front());
            in_fired = c_in_valid && c_in_ready;
            if (in_fired) begin
                exp_q.push_back(c_in_data);
                accepted++;
                if (exp_q.size() > 8) check_value("rand_capacity", exp_q.size(), 8);
            end
        end
        check_value("rand_accepted", accepted, 10000);
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
            @(posedge clock); #1;
            c_in_valid = 0; c_out_ready = 1; #3;
            if (exp_q.size() == 0) check_value("drain_empty_no_valid", c_out_valid, 0);
            if (c_out_valid && exp_q.size() > 0)
                check_value("drain_out_data", c_out_data, exp_q.pop_front());
        end
        check_value("drain_queue_empty", exp_q.size(), 0);
        @(posedge clock); #1; c_in_valid = 0; #3;
        check_value("drain_out_valid_low", c_out_valid, 0);

        // ---- DEPTH=0 bypass mirrors inputs combinationally
        for (int i = 0; i < 16; i++) begin
            @(posedge clock); #1;
            d_in_valid  = 1'($urandom_range(0, 1));
            d_in_data   = 1'($urandom_range(0, 1));
            d_out_ready = 1'($urandom_range(0, 1));
            #1;
            check_value("byp_out_valid", d_out_valid, d_in_valid);
            check_value("byp_out_data", d_out_data, d_in_data);
            check_value("byp_in_ready", d_in_ready, d_out_ready);
`ifdef READY_VALID_PIPE_OCCUPANCY_EN
            check_value("byp_occupancy", d_occ, 0);
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ready_valid_pipe.md
Name: ready_valid_pipe

Overview:
- Parametrised ready/valid retiming pipeline; successor to the plain single-bit pass-through wire.
- Carries a WIDTH-bit payload through DEPTH registered skid stages, at full throughput, with a registered in_ready.
- Used to cut long timing paths between core, bus bridges and peripherals.
- DEPTH=0 degenerates to a pure combinational pass-through.

Parameters:
- WIDTH, 32, payload width in bits; legal range 1..1024.
- DEPTH, 1, number of skid stages; legal range 0..8. 0 means combinational bypass.

Ports:
- clock  input  1  sole clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset; deassertion synchronised externally.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  pipeline can accept; registered for DEPTH>=1.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  downstream payload valid.
- out_ready  input  1  downstream can accept.
- out_data  output  WIDTH  downstream payload.

Behaviour:
- Transfer (fire) occurs when valid and ready are both high in the same cycle.
- DEPTH=0: out_valid=in_valid, out_data=in_data, in_ready=out_ready. No state, and reset_n is unused.
- DEPTH>=1: stage k output feeds stage k+1 input. Stage 0 is fed by the in_* ports; stage DEPTH-1 drives the out_* ports.
- Per-stage state machine uses a main register and a skid register. States are EMPTY, ONE and TWO.
  - Stage in_ready = (state != TWO). Stage out_valid = (state != EMPTY). Stage out_data = main.
  - EMPTY, in_fire: main<=in, go to ONE.
  - ONE, in_fire and no out_fire: skid<=in, go to TWO.
  - ONE, out_fire and no in_fire: go to EMPTY.
  - ONE, both fire: main<=in, stay in ONE.
  - TWO, out_fire: main<=skid, go to ONE. in_fire is impossible in TWO.
  - All other cases hold state.
- Latency: one cycle per stage through empty stages. A beat accepted at cycle t appears on out_valid at cycle t+DEPTH.
- Throughput: one beat per cycle sustained when out_ready stays high.
- Capacity: 2*DEPTH beats.
- in_ready is a pure function of flops, with no combinational path from out_ready.
- Ordering: strict FIFO; no beat is dropped or duplicated.
- Reset:
  - Asynchronous assertion forces every stage to EMPTY.
  - Outputs under reset: out_valid=0, in_ready=1. Asserting reset mid-transfer discards all in-flight beats.
  - Data registers are not reset. out_data is don't-care while out_valid=0.
- Backpressure:
  - out_ready low for 2*DEPTH or more accepted beats drives in_ready low.
  - The cycle after out_ready rises, in_ready returns high, delayed at most by the stage ripple.
- Protocol assumptions:
  - in_valid stays asserted and in_data stays stable until fired; no beat is withdrawn.
  - The block itself holds out_valid and out_data stable until fired.

Optional Feature:
- Macro READY_VALID_PIPE_OCCUPANCY_EN.
- When defined:
  - Adds output occupancy, width $clog2(2*DEPTH+1), giving the count of beats currently held (0..2*DEPTH).
  - Updated with in_fire minus out_fire; reset to 0.
  - Adds a simulation-only assertion that occupancy never exceeds 2*DEPTH.
- When undefined: the port and counter are absent; behaviour is otherwise identical.
- Has no effect for DEPTH=0, where the port is tied to 0 if present.

Decomposition:
- Shared package holds:
  - stage-state enum: EMPTY=2'd0, ONE=2'd1, TWO=2'd2;
  - constants MAX_DEPTH=8 and MAX_WIDTH=1024.
- One sub-module, ready_valid_skid_stage (WIDTH parameter, single stage as above), instantiated DEPTH times in a generate loop. The DEPTH=0 bypass is handled in the top level.

Test Plan:
- Reset, WIDTH=32, DEPTH=2: hold reset_n=0 with in_valid=1 -> out_valid=0, in_ready=1. Release reset, send 0xA5A5_0001 at cycle t -> out_valid=1 with that data at cycle t+2.
- Streaming, DEPTH=3, out_ready=1: send 100 consecutive beats 0..99 -> outputs 0..99 in order on 100 consecutive cycles after 3-cycle latency; in_ready never low.
- Backpressure, DEPTH=2, out_ready=0: offer beats continuously -> exactly 4 accepted, then in_ready=0. Raise out_ready -> beats drain in order 0,1,2,... with no loss or duplicate.
- Random stall, DEPTH=4: 20% random out_ready and in_valid toggling over 10k beats -> scoreboard matches exactly; with the macro defined, occupancy equals the scoreboard count every cycle.
- Reset mid-flight, DEPTH=2: 3 beats held, assert reset_n=0 asynchronously between edges -> out_valid drops immediately. After release, the next beat 0x55 emerges with no stale data before it.
- Bypass, DEPTH=0, WIDTH=1: toggle in_valid, in_data and out_ready -> outputs mirror inputs in the same cycle with zero latency.
